// File: rtl/loader_pkg.sv
// Shared definitions for the boot-time program loader: state codes,
// header field positions, target encoding and the decoded header type.
package loader_pkg;

    // FSM state encoding
    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_HEADER = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_SETTLE = 3'd3;
    localparam logic [2:0] ST_RUN    = 3'd4;
    localparam logic [2:0] ST_ERROR  = 3'd5;

    // Header word field positions
    localparam int HDR_TGT_BIT  = 31;
    localparam int HDR_LAST_BIT = 30;
    localparam int HDR_BASE_HI  = 29;
    localparam int HDR_BASE_LO  = 20;
    localparam int HDR_N_HI     = 9;
    localparam int HDR_N_LO     = 0;

    // Target memory encoding (header bit 31)
    localparam logic TGT_IMEM = 1'b0;
    localparam logic TGT_DMEM = 1'b1;

    typedef struct packed {
        logic       tgt;
        logic       last;
        logic [9:0] base;
        logic [9:0] n;
    } hdr_t;

    // Word index to byte address on the external memory ports
    function automatic logic [31:0] word2byte(input logic [10:0] idx);
        return {19'd0, idx, 2'b00};
    endfunction

endpackage

// File: rtl/loader_hdr_check.sv
// Combinational header decoder. Splits the header word into its fields and
// flags frames whose last word would land past the end of the target memory.
module loader_hdr_check
    import loader_pkg::*;
#(
    parameter int IMEM_WORDS = 512,
    parameter int DMEM_WORDS = 1024
) (
    input  logic [31:0] i_hdr,
    output hdr_t        o_hdr,
    output logic        o_ovf
);

    localparam logic [10:0] IMEM_DEPTH = 11'(IMEM_WORDS);
    localparam logic [10:0] DMEM_DEPTH = 11'(DMEM_WORDS);

    logic [10:0] w_sum;
    logic [10:0] w_depth;
    logic        w_unused;

    // Field extraction, 11-bit end index and overflow compare
    always_comb begin
        o_hdr.tgt  = i_hdr[HDR_TGT_BIT];
        o_hdr.last = i_hdr[HDR_LAST_BIT];
        o_hdr.base = i_hdr[HDR_BASE_HI:HDR_BASE_LO];
        o_hdr.n    = i_hdr[HDR_N_HI:HDR_N_LO];
        w_sum      = {1'b0, o_hdr.base} + {1'b0, o_hdr.n};
        w_depth    = (o_hdr.tgt == TGT_DMEM) ? DMEM_DEPTH : IMEM_DEPTH;
        o_ovf      = (w_sum > w_depth);
    end

    // Bits [19:10] carry no meaning
    assign w_unused = &{1'b0, i_hdr[19:10]};

endmodule

// File: rtl/reg_arstn_en.sv
// Generic enabled register with asynchronous active-low clear.
module reg_arstn_en #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         arst_n,
    input  logic         i_en,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);

    // Load on enable, clear to zero on reset
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n)   o_q <= '0;
        else if (i_en) o_q <= i_d;
    end

endmodule

// File: rtl/prog_loader.sv
// Boot-time sequencer: takes a framed word stream, writes each data word
// into instruction or data memory, then enables the CPU until stopped.
module prog_loader
    import loader_pkg::*;
#(
    parameter int IMEM_WORDS = 512,
    parameter int DMEM_WORDS = 1024
) (
    input  logic        clk,
    input  logic        arst_n,
    input  logic        start,
    input  logic        stop,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic [31:0] s_data,
    output logic [31:0] addr_ext,
    output logic        wen_ext,
    output logic [31:0] wdata_ext,
    output logic [31:0] addr_ext_2,
    output logic        wen_ext_2,
    output logic [31:0] wdata_ext_2,
    output logic        cpu_enable,
    output logic        busy,
    output logic        err
);

    logic [2:0]  r_state;
    logic        r_tgt;
    logic        r_last;
    logic [9:0]  r_base;
    logic [9:0]  r_n;
    logic [9:0]  r_cnt;

    hdr_t        w_hdr;
    logic        w_ovf;
    logic        w_hs;
    logic        w_wr;
    logic        w_wr_i;
    logic        w_wr_d;
    logic [10:0] w_idx;
    logic [31:0] w_waddr;
    logic [9:0]  w_cnt_nx;

    loader_hdr_check #(
        .IMEM_WORDS (IMEM_WORDS),
        .DMEM_WORDS (DMEM_WORDS)
    ) u_hdr (
        .i_hdr (s_data),
        .o_hdr (w_hdr),
        .o_ovf (w_ovf)
    );

    // Ready comes from state alone, never from s_valid
    assign s_ready    = (r_state == ST_HEADER) || (r_state == ST_DATA);
    assign busy       = (r_state == ST_HEADER) || (r_state == ST_DATA) || (r_state == ST_SETTLE);
    assign cpu_enable = (r_state == ST_RUN);
    assign err        = (r_state == ST_ERROR);

    assign w_hs     = s_valid && s_ready;
    assign w_wr     = w_hs && (r_state == ST_DATA);
    assign w_wr_i   = w_wr && (r_tgt == TGT_IMEM);
    assign w_wr_d   = w_wr && (r_tgt == TGT_DMEM);
    assign w_idx    = {1'b0, r_base} + {1'b0, r_cnt};
    assign w_waddr  = word2byte(w_idx);
    assign w_cnt_nx = r_cnt + 10'd1;

    // Load sequencer: header decode, data counting, settle, run, error
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_state <= ST_IDLE;
            r_tgt   <= 1'b0;
            r_last  <= 1'b0;
            r_base  <= '0;
            r_n     <= '0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) r_state <= ST_HEADER;
                end
                ST_HEADER: begin
                    if (w_hs) begin
                        r_tgt  <= w_hdr.tgt;
                        r_last <= w_hdr.last;
                        r_base <= w_hdr.base;
                        r_n    <= w_hdr.n;
                        r_cnt  <= '0;
                        if (w_ovf)              r_state <= ST_ERROR;
                        else if (w_hdr.n == '0) r_state <= w_hdr.last ? ST_SETTLE : ST_HEADER;
                        else                    r_state <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (w_hs) begin
                        if (w_cnt_nx == r_n) begin
                            r_cnt   <= '0;
                            r_state <= r_last ? ST_SETTLE : ST_HEADER;
                        end else begin
                            r_cnt   <= w_cnt_nx;
                        end
                    end
                end
                ST_SETTLE: r_state <= ST_RUN;
                ST_RUN: begin
                    if (stop) r_state <= ST_IDLE;
                end
                ST_ERROR: begin
                    if (start) r_state <= ST_HEADER;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Instruction memory port: one-cycle strobe, address/data hold between writes
    reg_arstn_en #(.W(1)) u_wen_i (
        .clk (clk), .arst_n (arst_n), .i_en (1'b1), .i_d (w_wr_i), .o_q (wen_ext)
    );
    reg_arstn_en #(.W(32)) u_addr_i (
        .clk (clk), .arst_n (arst_n), .i_en (w_wr_i), .i_d (w_waddr), .o_q (addr_ext)
    );
    reg_arstn_en #(.W(32)) u_data_i (
        .clk (clk), .arst_n (arst_n), .i_en (w_wr_i), .i_d (s_data), .o_q (wdata_ext)
    );

    // Data memory port
    reg_arstn_en #(.W(1)) u_wen_d (
        .clk (clk), .arst_n (arst_n), .i_en (1'b1), .i_d (w_wr_d), .o_q (wen_ext_2)
    );
    reg_arstn_en #(.W(32)) u_addr_d (
        .clk (clk), .arst_n (arst_n), .i_en (w_wr_d), .i_d (w_waddr), .o_q (addr_ext_2)
    );
    reg_arstn_en #(.W(32)) u_data_d (
        .clk (clk), .arst_n (arst_n), .i_en (w_wr_d), .i_d (s_data), .o_q (wdata_ext_2)
    );

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: framed loads, overflow, stalls, reset, run/stop.
module tb_prog_loader;

    logic        clk = 1'b0;
    logic        arst_n, start, stop, s_valid;
    logic [31:0] s_data;
    logic        s_ready;
    logic [31:0] addr_ext, wdata_ext, addr_ext_2, wdata_ext_2;
    logic        wen_ext, wen_ext_2, cpu_enable, busy, err;

    int checks = 0;
    int failures = 0;

    logic [31:0] iaddr_q[$], idata_q[$], daddr_q[$], ddata_q[$];

    prog_loader #(.IMEM_WORDS(512), .DMEM_WORDS(1024)) dut (
        .clk (clk), .arst_n (arst_n), .start (start), .stop (stop),
        .s_valid (s_valid), .s_ready (s_ready), .s_data (s_data),
        .addr_ext (addr_ext), .wen_ext (wen_ext), .wdata_ext (wdata_ext),
        .addr_ext_2 (addr_ext_2), .wen_ext_2 (wen_ext_2), .wdata_ext_2 (wdata_ext_2),
        .cpu_enable (cpu_enable), .busy (busy), .err (err)
    );

    always #5 clk = ~clk;

    // Memory-side write log, sampled on the falling edge
    always @(negedge clk) begin
        if (wen_ext)   begin iaddr_q.push_back(addr_ext);   idata_q.push_back(wdata_ext);   end
        if (wen_ext_2) begin daddr_q.push_back(addr_ext_2); ddata_q.push_back(wdata_ext_2); end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic clear_logs();
        iaddr_q.delete(); idata_q.delete(); daddr_q.delete(); ddata_q.delete();
    endtask

    task automatic pulse_start();
        start = 1'b1; tick(); start = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1; tick(); stop = 1'b0;
    endtask

    // Present one word and hold it until accepted; returns one cycle after the handshake
    task automatic send(input logic [31:0] d);
        int n = 0;
        s_valid = 1'b1; s_data = d;
        while (!s_ready && n < 20) begin tick(); n++; end
        checks++;
        if (!s_ready) begin failures++; $display("FAIL send_timeout word=%h s_ready=%b required=1", d, s_ready); end
        tick();
        s_valid = 1'b0;
    endtask

    task automatic test_reset();
        arst_n = 1'b0; start = 1'b0; stop = 1'b0; s_valid = 1'b0; s_data = '0;
        #12;
        checks++; if ({wen_ext, wen_ext_2, cpu_enable, busy, err, s_ready} !== 6'b0) begin failures++; $display("FAIL reset_flags got=%b required=000000", {wen_ext, wen_ext_2, cpu_enable, busy, err, s_ready}); end
        checks++; if ({addr_ext, wdata_ext, addr_ext_2, wdata_ext_2} !== 128'd0) begin failures++; $display("FAIL reset_buses got=%h required=0", {addr_ext, wdata_ext, addr_ext_2, wdata_ext_2}); end
        tick(); arst_n = 1'b1; tick();
        checks++; if (s_ready !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL idle_after_reset ready=%b busy=%b required=0 0", s_ready, busy); end
    endtask

    task automatic test_single();
        clear_logs();
        pulse_start();
        checks++; if (s_ready !== 1'b1 || busy !== 1'b1) begin failures++; $display("FAIL header_ready ready=%b busy=%b required=1 1", s_ready, busy); end
        send(32'h4000_0003);
        send(32'h2008_0005);
        send(32'h2009_0007);
        send(32'h0109_5020);
        checks++; if (wen_ext !== 1'b1 || addr_ext !== 32'h8 || cpu_enable !== 1'b0) begin failures++; $display("FAIL single_last_wen wen=%b addr=%h en=%b required=1 8 0", wen_ext, addr_ext, cpu_enable); end
        tick();
        checks++; if (cpu_enable !== 1'b1 || wen_ext !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL single_enable en=%b wen=%b busy=%b required=1 0 0", cpu_enable, wen_ext, busy); end
        checks++; if (iaddr_q.size() != 3 || daddr_q.size() != 0) begin failures++; $display("FAIL single_count imem=%0d dmem=%0d required=3 0", iaddr_q.size(), daddr_q.size()); end
        checks++; if (iaddr_q[0] !== 32'h0 || iaddr_q[1] !== 32'h4 || iaddr_q[2] !== 32'h8) begin failures++; $display("FAIL single_addrs got=%h %h %h required=0 4 8", iaddr_q[0], iaddr_q[1], iaddr_q[2]); end
        checks++; if (idata_q[0] !== 32'h2008_0005 || idata_q[1] !== 32'h2009_0007 || idata_q[2] !== 32'h0109_5020) begin failures++; $display("FAIL single_data got=%h %h %h required=20080005 20090007 01095020", idata_q[0], idata_q[1], idata_q[2]); end
        pulse_stop();
        checks++; if (cpu_enable !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL stop_run en=%b busy=%b required=0 0", cpu_enable, busy); end
    endtask

    task automatic test_two_frames();
        clear_logs();
        pulse_start();
        send(32'h0000_0002);
        send(32'h1111_1111);
        send(32'h2222_2222);
        send(32'hC100_0001);   // data memory, last, base 16, N 1
        send(32'hDEAD_BEEF);
        checks++; if (wen_ext_2 !== 1'b1 || addr_ext_2 !== 32'h40 || wdata_ext_2 !== 32'hDEAD_BEEF) begin failures++; $display("FAIL dmem_write wen=%b addr=%h data=%h required=1 40 deadbeef", wen_ext_2, addr_ext_2, wdata_ext_2); end
        checks++; if (wen_ext !== 1'b0 || addr_ext !== 32'h4 || wdata_ext !== 32'h2222_2222) begin failures++; $display("FAIL imem_hold wen=%b addr=%h data=%h required=0 4 22222222", wen_ext, addr_ext, wdata_ext); end
        tick();
        checks++; if (cpu_enable !== 1'b1) begin failures++; $display("FAIL two_enable got=%b required=1", cpu_enable); end
        checks++; if (iaddr_q.size() != 2 || daddr_q.size() != 1) begin failures++; $display("FAIL two_counts imem=%0d dmem=%0d required=2 1", iaddr_q.size(), daddr_q.size()); end
        checks++; if (iaddr_q[0] !== 32'h0 || iaddr_q[1] !== 32'h4 || idata_q[1] !== 32'h2222_2222) begin failures++; $display("FAIL two_imem got=%h %h %h required=0 4 22222222", iaddr_q[0], iaddr_q[1], idata_q[1]); end
        pulse_stop();
    endtask

    task automatic test_overflow();
        clear_logs();
        pulse_start();
        send(32'h1FF0_0002);   // imem base 511, N 2
        checks++; if (err !== 1'b1 || s_ready !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL imem_ovf err=%b ready=%b busy=%b required=1 0 0", err, s_ready, busy); end
        tick(); tick();
        checks++; if (err !== 1'b1) begin failures++; $display("FAIL err_sticky got=%b required=1", err); end
        pulse_start();
        checks++; if (err !== 1'b0 || s_ready !== 1'b1) begin failures++; $display("FAIL err_clear err=%b ready=%b required=0 1", err, s_ready); end
        send(32'hBFF0_0002);   // dmem base 1023, N 2
        checks++; if (err !== 1'b1) begin failures++; $display("FAIL dmem_ovf got=%b required=1", err); end
        pulse_start();
        send(32'h5FF0_0001);   // imem base 511, N 1, last: exact fit
        send(32'hCAFE_F00D);
        checks++; if (wen_ext !== 1'b1 || addr_ext !== 32'h7FC || wdata_ext !== 32'hCAFE_F00D) begin failures++; $display("FAIL edge_fit wen=%b addr=%h data=%h required=1 7fc cafef00d", wen_ext, addr_ext, wdata_ext); end
        tick();
        checks++; if (cpu_enable !== 1'b1 || err !== 1'b0) begin failures++; $display("FAIL ovf_recover en=%b err=%b required=1 0", cpu_enable, err); end
        checks++; if (iaddr_q.size() != 1 || daddr_q.size() != 0) begin failures++; $display("FAIL ovf_counts imem=%0d dmem=%0d required=1 0", iaddr_q.size(), daddr_q.size()); end
        pulse_stop();
    endtask

    task automatic test_toggle();
        clear_logs();
        pulse_start();
        send(32'h4020_0004);   // imem base 2, N 4, last
        for (int i = 0; i < 4; i++) begin
            send(32'hA0 + 32'(i));
            tick();
        end
        checks++; if (cpu_enable !== 1'b1) begin failures++; $display("FAIL toggle_enable got=%b required=1", cpu_enable); end
        checks++; if (iaddr_q.size() != 4) begin failures++; $display("FAIL toggle_count got=%0d required=4", iaddr_q.size()); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (iaddr_q[i] !== 32'(8 + 4 * i) || idata_q[i] !== 32'hA0 + 32'(i)) begin failures++; $display("FAIL toggle_word%0d addr=%h data=%h required=%h %h", i, iaddr_q[i], idata_q[i], 32'(8 + 4 * i), 32'hA0 + 32'(i)); end
        end
        pulse_stop();
    endtask

    task automatic test_reset_mid();
        clear_logs();
        pulse_start();
        send(32'h0040_0004);   // imem base 4, N 4, not last
        send(32'h0000_AAAA);
        send(32'h0000_BBBB);
        tick();
        arst_n = 1'b0; #1;
        checks++; if ({wen_ext, wen_ext_2, cpu_enable, busy, err, s_ready} !== 6'b0) begin failures++; $display("FAIL midrst_flags got=%b required=000000", {wen_ext, wen_ext_2, cpu_enable, busy, err, s_ready}); end
        checks++; if (addr_ext !== 32'h0 || wdata_ext !== 32'h0) begin failures++; $display("FAIL midrst_bus addr=%h data=%h required=0 0", addr_ext, wdata_ext); end
        tick(); arst_n = 1'b1; tick();
        s_valid = 1'b1; s_data = 32'h0000_CCCC;
        tick(); tick();
        checks++; if (busy !== 1'b0 || s_ready !== 1'b0) begin failures++; $display("FAIL midrst_idle busy=%b ready=%b required=0 0", busy, s_ready); end
        s_valid = 1'b0;
        tick();
        checks++; if (iaddr_q.size() != 2 || iaddr_q[0] !== 32'h10 || iaddr_q[1] !== 32'h14 || idata_q[1] !== 32'h0000_BBBB) begin failures++; $display("FAIL midrst_kept n=%0d a0=%h a1=%h d1=%h required=2 10 14 bbbb", iaddr_q.size(), iaddr_q[0], iaddr_q[1], idata_q[1]); end
    endtask

    task automatic test_start_stop();
        clear_logs();
        pulse_start();
        send(32'h0000_0000);   // empty, not last: stays in HEADER
        checks++; if (s_ready !== 1'b1 || busy !== 1'b1) begin failures++; $display("FAIL empty_hdr ready=%b busy=%b required=1 1", s_ready, busy); end
        send(32'h4000_0000);   // empty, last
        checks++; if (busy !== 1'b1 || cpu_enable !== 1'b0 || s_ready !== 1'b0) begin failures++; $display("FAIL settle busy=%b en=%b ready=%b required=1 0 0", busy, cpu_enable, s_ready); end
        tick();
        checks++; if (cpu_enable !== 1'b1) begin failures++; $display("FAIL empty_enable got=%b required=1", cpu_enable); end
        start = 1'b1; stop = 1'b1;
        tick();
        start = 1'b0; stop = 1'b0;
        checks++; if (cpu_enable !== 1'b0 || busy !== 1'b0 || s_ready !== 1'b0) begin failures++; $display("FAIL stop_wins en=%b busy=%b ready=%b required=0 0 0", cpu_enable, busy, s_ready); end
        tick(); tick();
        checks++; if (busy !== 1'b0 || iaddr_q.size() != 0 || daddr_q.size() != 0) begin failures++; $display("FAIL no_load busy=%b imem=%0d dmem=%0d required=0 0 0", busy, iaddr_q.size(), daddr_q.size()); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_two_frames();
        test_overflow();
        test_toggle();
        test_reset_mid();
        test_start_stop();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
